// File: rtl/branch_resolver.sv
// Conditional branch resolver: evaluates a 3-bit condition against the 2-bit status code,
// waits out in-flight status writes, then issues a one-cycle redirect and a fixed-length flush.
module branch_resolver #(
    parameter int unsigned PC_WIDTH     = 16,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                brValid,
    output logic                brReady,
    input  logic [2:0]          brCond,
    input  logic [PC_WIDTH-1:0] brTarget,
    input  logic [1:0]          srIn,
    input  logic                srPending,
    output logic                stall,
    output logic                pcSel,
    output logic [PC_WIDTH-1:0] pcTarget,
    output logic                flush,
    output logic [7:0]          takenCnt
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SR,
        S_FLUSH
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    flush_cnt;
    logic [2:0]          cond_q;
    logic [PC_WIDTH-1:0] target_q;

    logic                accept;
    logic                resolve_now;
    logic [2:0]          eval_cond;
    logic [PC_WIDTH-1:0] eval_target;
    logic                taken;

    // Status 00 sets no flag, so only the unconditional code can be taken.
    function automatic logic cond_met(input logic [2:0] cond, input logic [1:0] sr);
        logic neg;
        logic zero;
        logic pos;
        neg  = (sr == 2'b01);
        zero = (sr == 2'b10);
        pos  = (sr == 2'b11);
        case (cond)
            3'b000:  cond_met = 1'b1;
            3'b001:  cond_met = zero;
            3'b010:  cond_met = neg | pos;
            3'b011:  cond_met = neg;
            3'b100:  cond_met = pos;
            3'b101:  cond_met = neg | zero;
            3'b110:  cond_met = pos | zero;
            default: cond_met = 1'b0;
        endcase
    endfunction

    assign brReady     = (state == S_IDLE);
    assign accept      = brValid && brReady;
    // In IDLE the request resolves straight off the inputs; in WAIT_SR off the latched copy.
    assign resolve_now = (accept && !srPending) || ((state == S_WAIT_SR) && !srPending);
    assign eval_cond   = (state == S_IDLE) ? brCond   : cond_q;
    assign eval_target = (state == S_IDLE) ? brTarget : target_q;
    assign taken       = resolve_now && cond_met(eval_cond, srIn);

    // State, latched request and registered outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            flush_cnt <= '0;
            cond_q    <= '0;
            target_q  <= '0;
            stall     <= 1'b0;
            pcSel     <= 1'b0;
            pcTarget  <= '0;
            flush     <= 1'b0;
            takenCnt  <= '0;
        end else begin
            pcSel <= taken;
            if (taken) begin
                pcTarget <= eval_target;
            end
            if (taken && (takenCnt != 8'hFF)) begin
                takenCnt <= takenCnt + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cond_q   <= brCond;
                        target_q <= brTarget;
                        if (srPending) begin
                            state <= S_WAIT_SR;
                            stall <= 1'b1;
                        end else if (taken) begin
                            state     <= S_FLUSH;
                            flush     <= 1'b1;
                            flush_cnt <= CNT_W'(FLUSH_CYCLES);
                        end
                    end
                end
                S_WAIT_SR: begin
                    if (!srPending) begin
                        stall <= 1'b0;
                        if (taken) begin
                            state     <= S_FLUSH;
                            flush     <= 1'b1;
                            flush_cnt <= CNT_W'(FLUSH_CYCLES);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_FLUSH: begin
                    flush_cnt <= flush_cnt - CNT_W'(1);
                    if (flush_cnt == CNT_W'(1)) begin
                        state <= S_IDLE;
                        flush <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolves conditional branches against the 2-bit status code produced by the datapath status register. It accepts one branch request at a time and waits while a status write is still in flight. It then drives a one-cycle PC redirect and a fixed-length pipeline flush. It sits between decode/execute control and the PC-select mux, and also keeps a saturating count of taken branches.

## Interface
- PC_WIDTH, 16, width of branch target and redirect address
- FLUSH_CYCLES, 2, cycles flush stays high after a taken branch (legal range 1..15)
- CLK  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- brValid  in  1  branch request present
- brReady  out  1  unit can accept a request (high only in IDLE)
- brCond  in  3  condition code, sampled on accept
- brTarget  in  PC_WIDTH  branch target, sampled on accept
- srIn  in  2  current status code from the status register
- srPending  in  1  a status write (SRw) is in flight; srIn is not yet valid for this branch
- stall  out  1  upstream hold while waiting on status
- pcSel  out  1  one-cycle redirect strobe
- pcTarget  out  PC_WIDTH  redirect address, valid while pcSel=1
- flush  out  1  squash younger instructions
- takenCnt  out  8  saturating count of taken branches

## Operation
- Status encoding: 00 none (post-reset, no flags), 01 negative, 10 zero, 11 positive.
- Condition codes:
  - 000 always
  - 001 EQ: zero
  - 010 NE: negative or positive
  - 011 LT: negative
  - 100 GT: positive
  - 101 LE: negative or zero
  - 110 GE: positive or zero
  - 111 never
- With status 00, only code 000 is taken; all other codes are not taken.
- Accept happens when brValid && brReady on a rising edge. brCond and brTarget are latched into internal registers at accept.
- States: IDLE, WAIT_SR, FLUSH.
- IDLE, accept with srPending=0: evaluate the condition against srIn at that edge.
  - Taken: go to FLUSH and load the flush counter with FLUSH_CYCLES.
  - Not taken: stay in IDLE.
- IDLE, accept with srPending=1: go to WAIT_SR. The condition is not evaluated.
- WAIT_SR: stay while srPending=1. On the first edge with srPending=0, evaluate the latched condition against srIn at that edge, then:
  - Taken: go to FLUSH.
  - Not taken: go to IDLE.
- FLUSH: decrement the counter each edge. Go to IDLE on the edge where the counter reaches 0.
- takenCnt increments by 1 on each taken resolution. It saturates at 255 and never wraps.
- brValid while brReady=0 is ignored. The requester holds the request until it is accepted.

## Timing
- Reset (asynchronous, reset=0) forces immediately:
  - state IDLE, counters 0
  - brReady=1
  - stall=0, pcSel=0, flush=0
  - pcTarget=0, takenCnt=0
- Reset asserted mid-WAIT_SR or mid-FLUSH aborts the operation. No pcSel pulse follows after reset is released.
- All outputs are registered except brReady, which is decoded directly from state.
- Taken resolution at edge N:
  - pcSel=1 and pcTarget=latched target during cycle N..N+1 only.
  - flush=1 for exactly FLUSH_CYCLES cycles starting at N.
  - brReady=0 during the same cycles.
  - brReady=1 from edge N+FLUSH_CYCLES.
- Not-taken resolution at edge N: no pcSel, no flush. brReady=1 from edge N.
- Accept with srPending=1 at edge N:
  - stall=1 from N until the resolving edge.
  - stall=0 at the resolving edge, which coincides with pcSel if taken.
- Best-case latency from accept to redirect: 0 wait cycles. The redirect is visible in the cycle after the accept edge.
- A request can be accepted on the same edge brReady rises. Back-to-back not-taken branches are accepted every cycle.

## Test plan
- Reset, then srIn=10, brCond=001, brTarget=0x0040, srPending=0 -> pcSel=1 and pcTarget=0x0040 for 1 cycle; flush high 2 cycles; takenCnt=1; brReady back after 2 cycles.
- srIn=01, brCond=100, then brCond=011 on the next cycle -> first branch not taken (no pcSel, brReady stays 1); second branch taken; takenCnt=1.
- Accept with srPending=1 held 3 cycles; srIn changes 11->10 on release; brCond=001 -> stall high 3 cycles; taken using srIn=10; pcSel on the release edge.
- srIn=00 (post-reset), each brCond 000..111 in turn -> only 000 taken; 111 never taken for any srIn value.
- reset pulled low during FLUSH (FLUSH_CYCLES=4, cycle 2) -> flush/pcSel/stall drop to 0 immediately; brReady=1; takenCnt=0.
- 300 taken brCond=000 branches -> takenCnt saturates at 255 and holds.
